match_controller: RTL
=====================

Name: match_controller

Overview:
- Sequences a two-innings cricket match. Consumes one ball outcome per `ball_valid` pulse and keeps per-innings runs, wickets and balls.
- Drives the scoreboard inputs: `binary_runs`, `binary_wickets`, `inning_over`, `game_over`, `winner`.
- Sits between the debounced player-input logic and the BCD/7-segment display path.

Parameters:
- BALLS_PER_INNING, 12, legal balls per innings (1..63).
- MAX_WICKETS, 10, wickets that end an innings (1..15).
- BREAK_CYCLES, 4, minimum clocks held in BREAK before `start` is honoured (>=1).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: begin match / begin innings 2
- ball_valid  input  1  single-cycle pulse: one ball outcome present
- run_code  input  3  runs scored on this ball, 0..6 (7 is illegal)
- is_wicket  input  1  ball is a dismissal (runs on a wicket ball still count)
- binary_runs  output  8  runs of the innings in play (innings-2 runs once game over)
- binary_wickets  output  4  wickets of the innings in play
- balls_left  output  6  legal balls remaining in the current innings
- batting_team  output  1  0 = team 1, 1 = team 2
- inning_over  output  1  high in BREAK state only
- game_over  output  1  high in DONE state only
- winner  output  1  0 = team 1, 1 = team 2; valid only while game_over = 1
- ball_accept  output  1  registered one-cycle acknowledge of an accepted ball

Behaviour:
- Reset (async assert, synchronous release): state = IDLE; all counters, scores and outputs = 0; `balls_left` = BALLS_PER_INNING.
- States: IDLE, INN1, BREAK, INN2, DONE. All outputs are registered.
- IDLE: `start` -> INN1. Clear runs, wickets and `target`; `balls_left` = BALLS_PER_INNING; `batting_team` = 0.
- INN1 / INN2 ball handling: a ball is accepted when `ball_valid` = 1 and `run_code` != 7.
  - On acceptance: runs += run_code, saturating at 255. Wickets += `is_wicket`. `balls_left` -= 1. `ball_accept` = 1 for the next cycle only.
  - Illegal `run_code` = 7: ball ignored, no counter changes, no ack.
  - `ball_valid` outside INN1/INN2 is ignored.
- Innings 1 end: evaluated with the updated counts of the accepted ball. Ends when wickets == MAX_WICKETS or `balls_left` reaches 0.
  - On end: `target` latches the final innings-1 runs; state -> BREAK.
- BREAK: `inning_over` = 1 and the innings-1 totals remain on the outputs.
  - An internal counter runs for BREAK_CYCLES clocks. `start` arriving earlier is dropped, not queued.
  - `start` after the counter expires -> INN2: runs/wickets cleared, `balls_left` = BALLS_PER_INNING, `batting_team` = 1.
- INN2 end: evaluated with the updated counts, in priority order:
  1. runs > `target` -> DONE, `winner` = 1. This takes precedence even if the same ball is the last ball or a wicket.
  2. wickets == MAX_WICKETS or `balls_left` == 0 -> DONE, `winner` = 0. Ties go to team 1.
- Saturation: if innings-1 saturated at 255, team 2 cannot exceed the target, so team 1 wins.
- DONE: `game_over` = 1 and `winner` is held. Final innings-2 scores remain on the outputs.
  - `start` -> IDLE-equivalent restart: counters cleared and state -> INN1 in the same step.
  - `ball_valid` is ignored.
- `start` during INN1/INN2 is ignored.
- A ball and `start` in the same cycle: the ball is processed per the current state; `start` follows the state rules above.
- `reset_n` low at any time, mid-ball or mid-BREAK, immediately forces the reset values.
- `inning_over` and `game_over` are never high together.

Test Plan:
- Reset, `start`, 12 balls of `run_code` = 1 -> after the 12th ack: `inning_over` = 1, `binary_runs` = 12, `balls_left` = 0, `target` = 12.
- Innings 1 with 10 consecutive wicket balls of 0 runs -> BREAK after the 10th ball, `binary_wickets` = 10, `balls_left` = 2.
- `start` 1 cycle into BREAK -> ignored. `start` after 4 cycles -> INN2, `batting_team` = 1, `binary_runs` = 0.
- Target 12; innings 2 balls of 6, 6, 1 -> DONE after the third ball, `winner` = 1, `binary_runs` = 13, `balls_left` = 9.
- Target 12; innings 2 ends on 12 runs with balls exhausted -> DONE, `winner` = 0. Then `run_code` = 7 and `ball_valid` in DONE -> no change.
- 43 sixes plus four in innings 1 with BALLS_PER_INNING = 63 -> `binary_runs` saturates at 255. Pulse `reset_n` low mid-INN2 -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/match_controller.sv
// Two-innings cricket match sequencer. Counts runs, wickets and balls for the
// innings in play, latches the innings-1 target, enforces a minimum break
// between innings and decides the winner for the scoreboard/display path.
module match_controller #(
  parameter int BALLS_PER_INNING = 12,
  parameter int MAX_WICKETS      = 10,
  parameter int BREAK_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       ball_valid,
  input  logic [2:0] run_code,
  input  logic       is_wicket,
  output logic [7:0] binary_runs,
  output logic [3:0] binary_wickets,
  output logic [5:0] balls_left,
  output logic       batting_team,
  output logic       inning_over,
  output logic       game_over,
  output logic       winner,
  output logic       ball_accept
);

  // Break counter holds BREAK_CYCLES-1 down to 0, so start is honoured on the
  // BREAK_CYCLES-th clock after entering BREAK.
  localparam int BCW = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;
  localparam logic [BCW-1:0] BRK_LOAD   = BCW'(BREAK_CYCLES - 1);
  localparam logic [5:0]     BALLS_INIT = 6'(BALLS_PER_INNING);
  localparam logic [3:0]     WKT_LIMIT  = 4'(MAX_WICKETS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INN1,
    S_BREAK,
    S_INN2,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [7:0]     target_q;
  logic [BCW-1:0] brk_cnt_q;

  logic       ball_ok_d;
  logic [7:0] runs_d;
  logic [3:0] wkts_d;
  logic [5:0] balls_d;
  logic       inn_end_d;

  // Runs never wrap: a saturated innings-1 total of 255 cannot be beaten.
  function automatic logic [7:0] sat_add_runs(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Candidate counts if the ball presented this cycle is accepted.
  always_comb begin
    ball_ok_d = 1'b0;
    if ((state_q == S_INN1) || (state_q == S_INN2))
      ball_ok_d = ball_valid && (run_code != 3'd7);
    runs_d    = sat_add_runs(binary_runs, run_code);
    wkts_d    = binary_wickets + {3'd0, is_wicket};
    balls_d   = balls_left - 6'd1;
    inn_end_d = (wkts_d == WKT_LIMIT) || (balls_d == 6'd0);
  end

  // Match FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      target_q       <= 8'd0;
      brk_cnt_q      <= '0;
      binary_runs    <= 8'd0;
      binary_wickets <= 4'd0;
      balls_left     <= BALLS_INIT;
      batting_team   <= 1'b0;
      inning_over    <= 1'b0;
      game_over      <= 1'b0;
      winner         <= 1'b0;
      ball_accept    <= 1'b0;
    end else begin
      ball_accept <= ball_ok_d;
      if (ball_ok_d) begin
        binary_runs    <= runs_d;
        binary_wickets <= wkts_d;
        balls_left     <= balls_d;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q        <= S_INN1;
            target_q       <= 8'd0;
            binary_runs    <= 8'd0;
            binary_wickets <= 4'd0;
            balls_left     <= BALLS_INIT;
            batting_team   <= 1'b0;
            game_over      <= 1'b0;
            winner         <= 1'b0;
          end
        end
        S_INN1: begin
          if (ball_ok_d && inn_end_d) begin
            state_q     <= S_BREAK;
            target_q    <= runs_d;
            brk_cnt_q   <= BRK_LOAD;
            inning_over <= 1'b1;
          end
        end
        S_BREAK: begin
          if (brk_cnt_q != '0) begin
            brk_cnt_q <= brk_cnt_q - 1'b1;
          end else if (start) begin
            state_q        <= S_INN2;
            binary_runs    <= 8'd0;
            binary_wickets <= 4'd0;
            balls_left     <= BALLS_INIT;
            batting_team   <= 1'b1;
            inning_over    <= 1'b0;
          end
        end
        S_INN2: begin
          if (ball_ok_d) begin
            if (runs_d > target_q) begin
              state_q   <= S_DONE;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else if (inn_end_d) begin
              state_q   <= S_DONE;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
